// File: rtl/dram_block_port.sv
// dram_block_port: moves one whole L2 block at a time between the cache side
// and the subblock-streamed memory port. Writes leave as SUBBLOCKS strobed
// beats; read beats are gathered by index into a full block.
// Optional read watchdog: define DRAM_PORT_TIMEOUT_EN.
module dram_block_port #(
    parameter int unsigned ADDR_BITS      = 32,
    parameter int unsigned BLOCK_BITS     = 512,
    parameter int unsigned SUBBLOCKS      = 4,
    parameter int unsigned SUB_LOG2       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    // cache side
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_BITS-1:0]             req_addr,
    input  logic [BLOCK_BITS-1:0]            req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_is_write,
    output logic                             rsp_err,
    output logic [BLOCK_BITS-1:0]            rsp_rdata,
    // memory side
    output logic [ADDR_BITS-1:0]             addr,
    output logic                             en,
    output logic                             we,
    output logic [SUB_LOG2-1:0]              dinDstrobe,
    output logic [BLOCK_BITS/SUBBLOCKS-1:0]  din,
    input  logic [SUB_LOG2-1:0]              doutDstrobe,
    input  logic [BLOCK_BITS/SUBBLOCKS-1:0]  dout,
    input  logic                             dready,
    input  logic                             accR,
    input  logic                             accW
);

    localparam int unsigned BEAT_BITS   = BLOCK_BITS / SUBBLOCKS;
    localparam int unsigned BLOCK_BYTES = BLOCK_BITS / 8;
    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(BLOCK_BYTES - 1);
    localparam logic [SUB_LOG2-1:0]  LAST_BEAT  = SUB_LOG2'(SUBBLOCKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        WR_BURST,
        RSP
    } state_t;

    state_t                               state;
    logic [SUBBLOCKS-1:0]                 rx_mask;
    logic [SUBBLOCKS-1:0]                 rx_mask_nxt;
    logic [SUB_LOG2-1:0]                  wr_cnt;
    logic [SUBBLOCKS-1:0][BEAT_BITS-1:0]  wdata_q;
    logic [SUBBLOCKS-1:0][BEAT_BITS-1:0]  rdata_q;
    logic                                 tmo_hit;

    assign req_ready = (state == IDLE) && reset;
    assign rsp_valid = (state == RSP);
    assign rsp_rdata = rdata_q;

    // received-beat mask including the beat on the bus this cycle
    always_comb begin
        rx_mask_nxt = rx_mask | (SUBBLOCKS'(1) << doutDstrobe);
    end

`ifdef DRAM_PORT_TIMEOUT_EN
    localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_BITS-1:0] tmo_cnt;
    logic                rsp_err_q;

    assign tmo_hit = (state == RD_DATA) && !dready && (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES));
    assign rsp_err = rsp_err_q;

    // watchdog: starts with the en pulse, restarts on every accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == RD_REQ && accR) begin
            tmo_cnt <= '0;
        end else if (state == RD_DATA) begin
            tmo_cnt <= dready ? '0 : tmo_cnt + TMO_BITS'(1);
        end
    end

    // error flag cleared on acceptance, set when the watchdog aborts a read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            rsp_err_q <= 1'b0;
        end else if (tmo_hit) begin
            rsp_err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // request sequencing and all registered memory-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rx_mask      <= '0;
            wr_cnt       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rsp_is_write <= 1'b0;
            addr         <= '0;
            en           <= 1'b0;
            we           <= 1'b0;
            dinDstrobe   <= '0;
            din          <= '0;
        end else begin
            en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr         <= req_addr & ALIGN_MASK;
                        wdata_q      <= req_wdata;
                        rdata_q      <= '0;
                        rx_mask      <= '0;
                        rsp_is_write <= 1'b0;
                        state        <= req_we ? WR_REQ : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (accR) begin
                        en    <= 1'b1;
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (dready) begin
                        rdata_q[doutDstrobe] <= dout;
                        rx_mask              <= rx_mask_nxt;
                        if (&rx_mask_nxt) begin
                            state <= RSP;
                        end
                    end else if (tmo_hit) begin
                        state <= RSP;
                    end
                end
                WR_REQ: begin
                    if (accW) begin
                        we         <= 1'b1;
                        wr_cnt     <= '0;
                        dinDstrobe <= '0;
                        din        <= wdata_q[0];
                        state      <= WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (wr_cnt == LAST_BEAT) begin
                        we           <= 1'b0;
                        rsp_is_write <= 1'b1;
                        state        <= RSP;
                    end else begin
                        wr_cnt     <= wr_cnt + SUB_LOG2'(1);
                        dinDstrobe <= wr_cnt + SUB_LOG2'(1);
                        din        <= wdata_q[wr_cnt + SUB_LOG2'(1)];
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rx_mask <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_block_port.sv
// Bench for dram_block_port: block-level reference model, a beat-level memory
// responder, and directed scenarios with hand-computed expectations.
module tb_dram_block_port;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 512;
    localparam int unsigned NS = 4;
    localparam int unsigned SL = 2;
    localparam int unsigned W  = BW / NS;
`ifdef DRAM_PORT_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 255;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_we;
    logic [AW-1:0]  req_addr;
    logic [BW-1:0]  req_wdata;
    logic           rsp_valid, rsp_ready, rsp_is_write, rsp_err;
    logic [BW-1:0]  rsp_rdata;
    logic [AW-1:0]  addr;
    logic           en, we;
    logic [SL-1:0]  dinDstrobe, doutDstrobe;
    logic [W-1:0]   din, dout;
    logic           dready, accR, accW;

    dram_block_port #(
        .ADDR_BITS(AW), .BLOCK_BITS(BW), .SUBBLOCKS(NS), .SUB_LOG2(SL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .addr(addr), .en(en), .we(we), .dinDstrobe(dinDstrobe), .din(din),
        .doutDstrobe(doutDstrobe), .dout(dout), .dready(dready),
        .accR(accR), .accW(accW)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- block-level reference model ----------------
    typedef struct packed {
        logic          is_write;
        logic          err;
        logic [BW-1:0] rdata;
    } exp_t;

    typedef struct packed {
        logic [SL-1:0] idx;
        logic [W-1:0]  data;
        logic [31:0]   c;
    } wbeat_t;

    exp_t          exp_q[$];
    logic [BW-1:0] model_mem [logic [AW-1:0]];
    logic [W-1:0]  resp_mem  [logic [AW+1:0]];
    wbeat_t        wr_log[$];
    logic [AW-1:0] exp_addr = '0;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(BW / 8 - 1);
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] blk);
        model_mem[align(a)] = blk;
        for (int k = 0; k < NS; k++) resp_mem[{align(a), SL'(k)}] = blk[k*W +: W];
    endtask

    // ---------------- monitor / compare process ----------------
    int unsigned   rsp_seen = 0, en_count = 0, rv_cycles = 0;
    int unsigned   en_cyc = 0, rsp_cyc = 0, acc_cyc = 0;
    logic [AW-1:0] en_addr = '0;
    logic [BW-1:0] last_rdata = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (en) begin
                    en_count++;
                    en_cyc  = cyc;
                    en_addr = addr;
                end
                if (rsp_valid) rv_cycles++;
                if (en || we) begin
                    chk("en_we_exclusive", BW'(en & we), BW'(0));
                    chk("mem_addr", BW'(addr), BW'(exp_addr));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", BW'(rsp_valid), BW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_is_write", BW'(rsp_is_write), BW'(e.is_write));
                        chk("rsp_err", BW'(rsp_err), BW'(e.err));
                        if (!e.is_write) chk("rsp_rdata", rsp_rdata, e.rdata);
                    end
                    last_rdata = rsp_rdata;
                    rsp_cyc    = cyc;
                    rsp_seen++;
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    int unsigned   lat = 5, gap = 0, beats_sent = 0;
    bit            resp_on = 1'b1, resp_busy = 1'b0;

    initial begin
        logic [AW-1:0] ra;
        logic [AW+1:0] key;
        dready = 1'b0; doutDstrobe = '0; dout = '0;
        forever begin
            @(negedge clk);
            if (reset && en && resp_on) begin
                ra = addr; resp_busy = 1'b1; beats_sent = 0;
                repeat (lat) @(negedge clk);
                for (int k = 0; k < NS; k++) begin
                    key = {ra, SL'(k)};
                    dready = 1'b1; doutDstrobe = SL'(k);
                    dout = resp_mem.exists(key) ? resp_mem[key] : '0;
                    beats_sent++;
                    @(negedge clk);
                    dready = 1'b0;
                    repeat (gap) @(negedge clk);
                end
                resp_busy = 1'b0;
            end
        end
    end

    // write beats land in the responder memory
    initial begin
        forever begin
            @(negedge clk);
            if (reset && we) begin
                resp_mem[{addr, dinDstrobe}] = din;
                wr_log.push_back(wbeat_t'{dinDstrobe, din, 32'(cyc)});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] wd);
        int unsigned n = 0;
        exp_t e;
        req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_accept_timeout", BW'(req_ready), BW'(1));
        end else begin
            acc_cyc    = cyc;
            exp_addr   = align(a);
            e.is_write = w;
            e.err      = 1'b0;
            e.rdata    = model_mem.exists(align(a)) ? model_mem[align(a)] : '0;
            if (w) model_mem[align(a)] = wd;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned max);
        int unsigned s = rsp_seen;
        int unsigned n = 0;
        while (rsp_seen == s && n < max) begin @(negedge clk); n++; end
        if (rsp_seen == s) chk("rsp_timeout", BW'(rsp_valid), BW'(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, BW'(addr), BW'(0));
        chk({tag, "_en_we"}, BW'({en, we}), BW'(0));
        chk({tag, "_dinDstrobe"}, BW'(dinDstrobe), BW'(0));
        chk({tag, "_din"}, BW'(din), BW'(0));
        chk({tag, "_rsp_rdata"}, rsp_rdata, BW'(0));
        chk({tag, "_rsp_flags"}, BW'({rsp_valid, rsp_is_write, rsp_err}), BW'(0));
        chk({tag, "_req_ready"}, BW'(req_ready), BW'(0));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [W-1:0]  ba, bb, bc, bd;
        logic [BW-1:0] wblk, xblk, yblk, pblk, qblk, snap;
        int unsigned   e0, r0, n;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; accR = 1'b1; accW = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", BW'(req_ready), BW'(1));

        // read, latency 5, beats A..D
        ba = {4{32'hAAAA_0001}}; bb = {4{32'hBBBB_0002}};
        bc = {4{32'hCCCC_0003}}; bd = {4{32'hDDDD_0004}};
        preload(32'h0001_0440, {bd, bc, bb, ba});
        e0 = en_count; r0 = rv_cycles; lat = 5;
        issue(1'b0, 32'h0001_0468, '0);
        wait_rsp(100);
        chk("t1_en_pulses", BW'(en_count - e0), BW'(1));
        chk("t1_en_addr", BW'(en_addr), BW'(32'h0001_0440));
        chk("t1_rdata_literal", last_rdata, {bd, bc, bb, ba});
        chk("t1_rsp_valid_cycles", BW'(rv_cycles - r0), BW'(1));
        chk("t1_rsp_latency", BW'(rsp_cyc - acc_cyc), BW'(11));

        // write with accW low for 3 cycles
        for (int i = 0; i < 16; i++) wblk[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        wr_log.delete();
        accW = 1'b0;
        issue(1'b1, 32'h0000_0200, wblk);
        repeat (3) begin
            chk("t2_no_we_while_accW_low", BW'(we), BW'(0));
            @(negedge clk);
        end
        accW = 1'b1;
        wait_rsp(100);
        chk("t2_beat_count", BW'(wr_log.size()), BW'(4));
        if (wr_log.size() == 4) begin
            chk("t2_first_din", BW'(wr_log[0].data), BW'(128'hC0DE_0003_C0DE_0002_C0DE_0001_C0DE_0000));
            for (int i = 0; i < 4; i++) begin
                chk("t2_strobe", BW'(wr_log[i].idx), BW'(i));
                chk("t2_din", BW'(wr_log[i].data), BW'(wblk[i*W +: W]));
                chk("t2_consecutive", BW'(wr_log[i].c - wr_log[0].c), BW'(i));
            end
        end

        // write 0x100 then read it back, accR low first
        for (int i = 0; i < 16; i++) xblk[i*32 +: 32] = 32'h5100_0000 ^ (32'(i) * 32'h0101_0101);
        issue(1'b1, 32'h0000_0100, xblk);
        wait_rsp(100);
        accR = 1'b0; e0 = en_count;
        issue(1'b0, 32'h0000_0100, '0);
        repeat (5) @(negedge clk);
        chk("t3_no_en_while_accR_low", BW'(en_count - e0), BW'(0));
        accR = 1'b1;
        wait_rsp(100);
        chk("t3_readback", last_rdata, xblk);

        // response back-pressure for 10 cycles
        for (int i = 0; i < 16; i++) yblk[i*32 +: 32] = 32'h7700_0000 + 32'(i * 3);
        preload(32'h0000_03C0, yblk);
        rsp_ready = 1'b0; lat = 2;
        issue(1'b0, 32'h0000_03C4, '0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("t4_rsp_valid_seen", BW'(rsp_valid), BW'(1));
        snap = rsp_rdata;
        chk("t4_rdata_literal", snap, yblk);
        repeat (10) begin
            @(negedge clk);
            chk("t4_rsp_valid_held", BW'(rsp_valid), BW'(1));
            chk("t4_rdata_stable", rsp_rdata, snap);
            chk("t4_req_ready_low", BW'(req_ready), BW'(0));
            chk("t4_no_mem_activity", BW'({en, we}), BW'(0));
        end
        rsp_ready = 1'b1;
        wait_rsp(10);

        // reset after two read beats
        for (int i = 0; i < 16; i++) pblk[i*32 +: 32] = 32'hBAD0_0000 + 32'(i);
        for (int i = 0; i < 16; i++) qblk[i*32 +: 32] = 32'h600D_0000 + 32'(i * 7);
        preload(32'h0000_0800, pblk);
        preload(32'h0000_0840, qblk);
        gap = 3; beats_sent = 0;
        issue(1'b0, 32'h0000_0800, '0);
        n = 0;
        while (beats_sent < 2 && n < 100) begin @(negedge clk); n++; end
        chk("t5_two_beats_sent", BW'(beats_sent >= 2), BW'(1));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("t5_reset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        r0 = rv_cycles; n = 0;
        while (resp_busy && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("t5_trailing_ignored", BW'(rv_cycles - r0), BW'(0));
        chk("t5_idle_after", BW'(req_ready), BW'(1));
        gap = 0;
        issue(1'b0, 32'h0000_0850, '0);
        wait_rsp(100);
        chk("t5_next_read", last_rdata, qblk);

        // silent responder
        resp_on = 1'b0;
        issue(1'b0, 32'h0000_0040, '0);
`ifdef DRAM_PORT_TIMEOUT_EN
        exp_q[exp_q.size()-1].err   = 1'b1;
        exp_q[exp_q.size()-1].rdata = '0;
        wait_rsp(100);
        chk("t6_timeout_cycle", BW'(rsp_cyc - en_cyc), BW'(17));
`else
        r0 = rv_cycles;
        repeat (1000) @(negedge clk);
        chk("t6_no_rsp_without_watchdog", BW'(rv_cycles - r0), BW'(0));
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
`endif
        resp_on = 1'b1;
        @(negedge clk);
        chk("exp_queue_drained", BW'(exp_q.size()), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
